// File: rtl/uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_framer
// Brief    : 8N1 serial receiver with a single-entry ready/valid holding
//            register. Define UART_RX_FRAME_ERR_EN to discard bad-stop-bit
//            characters and pulse frame_error instead of delivering them.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_framer #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       overrun,
    output logic       frame_error
);

    localparam int c_SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int c_SAMPLE_TIME      = c_SYMBOL_EDGE_TIME / 2;
    localparam int c_CNT_W            = $clog2(c_SYMBOL_EDGE_TIME);

    localparam logic [c_CNT_W-1:0] c_SYM_LAST    = c_CNT_W'(c_SYMBOL_EDGE_TIME - 1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(c_SAMPLE_TIME - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_deliver;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_overrun;
    logic               w_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= serial_in;
            r_rx_s    <= r_rx_meta;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic r_frame_error;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= (r_state == c_STOP) && (r_cnt == c_SYM_LAST) && !r_rx_s;
        end
    end

    assign frame_error = r_frame_error;
`else
    assign frame_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_deliver <= 1'b0;
        end else begin
            r_deliver <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (r_cnt == c_SAMPLE_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_state   <= c_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_cnt == c_SYM_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_STOP: begin
                    if (r_cnt == c_SYM_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_deliver <= 1'b1;
                            r_state   <= c_IDLE;
                        end else begin
`ifndef UART_RX_FRAME_ERR_EN
                            r_deliver <= 1'b1;
`endif
                            // Hold off until the line returns high so a break
                            // cannot masquerade as a new start bit.
                            r_state <= c_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_accept = r_valid & data_out_ready;

    // A load coinciding with a handshake keeps valid high with the new byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || w_accept) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_framer
// Brief    : Directed self-checking bench for uart_rx_framer at default rates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framer;

    localparam int c_BIT = 434;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       overrun;
    logic       frame_error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] rx_q[$];
    int         valid_cycles;
    int         ovr_cnt;
    int         fe_cnt;
    int         stab_err;
    logic       prev_valid;
    logic       prev_acc;
    logic [7:0] prev_data;

    uart_rx_framer dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overrun        (overrun),
        .frame_error    (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (data_out_valid) valid_cycles++;
            if (data_out_valid && data_out_ready) rx_q.push_back(data_out);
            if (overrun) ovr_cnt++;
            if (frame_error) fe_cnt++;
            if (prev_valid && !prev_acc && data_out != prev_data) stab_err++;
            prev_valid = data_out_valid;
            prev_acc   = data_out_valid && data_out_ready;
            prev_data  = data_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        valid_cycles = 0;
        ovr_cnt      = 0;
        fe_cnt       = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        tick(c_BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(c_BIT);
        end
        serial_in = stop_bit;
        tick(c_BIT);
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (idx < rx_q.size()) return {24'h0, rx_q[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        stab_err       = 0;
        prev_valid     = 1'b0;
        prev_acc       = 1'b0;
        prev_data      = 8'h00;
        clear_mon();
        rst            = 1'b0;
        serial_in      = 1'b1;
        data_out_ready = 1'b0;

        #1;
        check("reset_data", {24'h0, data_out}, 32'h00);
        check("reset_valid", {31'h0, data_out_valid}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);
        check("reset_frame_error", {31'h0, frame_error}, 32'h0);
        tick(5);
        rst = 1'b1;
        tick(20);

        // 1: single byte, consumer always ready
        data_out_ready = 1'b1;
        clear_mon();
        send_byte(8'hA5, 1'b1);
        tick(20);
        check("t1_count", rx_q.size(), 1);
        check("t1_data", q_at(0), 32'hA5);
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_overrun", ovr_cnt, 0);

        // 2: short low glitch must be rejected
        clear_mon();
        serial_in = 1'b0;
        tick(100);
        serial_in = 1'b1;
        tick(600);
        check("t2_glitch_valid", valid_cycles, 0);
        send_byte(8'h5A, 1'b1);
        tick(20);
        check("t2_count", rx_q.size(), 1);
        check("t2_data", q_at(0), 32'h5A);

        // 3: overrun when the holding register is full
        clear_mon();
        data_out_ready = 1'b0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        tick(20);
        check("t3_data_held", {24'h0, data_out}, 32'h12);
        check("t3_valid_held", {31'h0, data_out_valid}, 32'h1);
        check("t3_overrun_pulses", ovr_cnt, 1);
        data_out_ready = 1'b1;
        tick(1);
        check("t3_valid_cleared", {31'h0, data_out_valid}, 32'h0);
        check("t3_accepted", q_at(0), 32'h12);
        check("t3_accept_count", rx_q.size(), 1);

        // 4: bad stop bit with line held low
        clear_mon();
        send_byte(8'h55, 1'b0);
        tick(c_BIT);
        serial_in = 1'b1;
        tick(1000);
`ifdef UART_RX_FRAME_ERR_EN
        check("t4_count", rx_q.size(), 0);
        check("t4_valid_cycles", valid_cycles, 0);
        check("t4_frame_error", fe_cnt, 1);
`else
        check("t4_count", rx_q.size(), 1);
        check("t4_data", q_at(0), 32'h55);
        check("t4_frame_error", fe_cnt, 0);
`endif
        check("t4_overrun", ovr_cnt, 0);

        // 5: asynchronous reset in the middle of a frame
        clear_mon();
        data_out_ready = 1'b0;
        send_byte(8'h81, 1'b1);
        tick(20);
        check("t5_pre_valid", {31'h0, data_out_valid}, 32'h1);
        check("t5_pre_data", {24'h0, data_out}, 32'h81);
        serial_in = 1'b0;
        tick(c_BIT);
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'b1;
            tick(c_BIT);
        end
        serial_in = 1'b0;
        tick(200);
        rst = 1'b0;
        #1;
        check("t5_rst_data", {24'h0, data_out}, 32'h00);
        check("t5_rst_valid", {31'h0, data_out_valid}, 32'h0);
        check("t5_rst_overrun", {31'h0, overrun}, 32'h0);
        serial_in = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(20);
        clear_mon();
        data_out_ready = 1'b1;
        send_byte(8'h3C, 1'b1);
        tick(20);
        check("t5_count", rx_q.size(), 1);
        check("t5_data", q_at(0), 32'h3C);

        // 6: back-to-back frames with zero idle time
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(20);
        check("t6_count", rx_q.size(), 2);
        check("t6_first", q_at(0), 32'h00);
        check("t6_second", q_at(1), 32'hFF);
        check("t6_overrun", ovr_cnt, 0);

        check("data_stability", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
